// File: rtl/obi_rr_mgr_arbiter.sv
// N-to-1 OBI arbiter: round-robin A-phase arbitration with stall locking, and an
// in-order ID FIFO that routes each R-phase response back to the port that issued it.
module obi_rr_mgr_arbiter #(
  parameter int unsigned NumSbrPorts     = 4,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned NumMaxTrans     = 4,
  // Set to 0 only where responses with nothing outstanding are injected on purpose.
  parameter bit          FlagSpuriousRsp = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumSbrPorts-1:0]                sbr_req_i,
  output logic [NumSbrPorts-1:0]                sbr_gnt_o,
  input  logic [NumSbrPorts*AddrWidth-1:0]      sbr_addr_i,
  input  logic [NumSbrPorts-1:0]                sbr_we_i,
  input  logic [NumSbrPorts*(DataWidth/8)-1:0]  sbr_be_i,
  input  logic [NumSbrPorts*DataWidth-1:0]      sbr_wdata_i,
  output logic [NumSbrPorts-1:0]                sbr_rvalid_o,
  output logic [DataWidth-1:0]                  sbr_rdata_o,
  output logic                                  sbr_err_o,
  output logic                                  mgr_req_o,
  input  logic                                  mgr_gnt_i,
  output logic [AddrWidth-1:0]                  mgr_addr_o,
  output logic                                  mgr_we_o,
  output logic [DataWidth/8-1:0]                mgr_be_o,
  output logic [DataWidth-1:0]                  mgr_wdata_o,
  input  logic                                  mgr_rvalid_i,
  input  logic [DataWidth-1:0]                  mgr_rdata_i,
  input  logic                                  mgr_err_i
);

  localparam int unsigned IdxW = $clog2(NumSbrPorts);
  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {ARB, HOLD} state_e;

  state_e          state_q, state_d;
  idx_t            rr_ptr_q, lock_idx_q, winner, head_id;
  logic            fifo_full, fifo_empty, handshake, pop;
  idx_t            id_mem [NumMaxTrans];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  assign fifo_full  = (cnt_q == CntW'(NumMaxTrans));
  assign fifo_empty = (cnt_q == '0);

  // Round-robin scan starting at rr_ptr; a stalled request keeps its locked port.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic             found;
    logic [IdxW:0]    cand;
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NumSbrPorts; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumSbrPorts)) cand = cand - (IdxW+1)'(NumSbrPorts);
      if (!found && sbr_req_i[cand[IdxW-1:0]]) begin
        winner = cand[IdxW-1:0];
        found  = 1'b1;
      end
    end
    if (state_q == HOLD) winner = lock_idx_q;
  end

  always_comb begin
    mgr_req_o = 1'b0;
    if (rst_ni && !fifo_full) mgr_req_o = (state_q == HOLD) ? 1'b1 : |sbr_req_i;
  end

  assign handshake = mgr_req_o & mgr_gnt_i;

  always_comb begin
    sbr_gnt_o = '0;
    if (handshake) sbr_gnt_o[winner] = 1'b1;
  end

  assign mgr_addr_o  = sbr_addr_i[int'(winner)*AddrWidth +: AddrWidth];
  assign mgr_we_o    = sbr_we_i[winner];
  assign mgr_be_o    = sbr_be_i[int'(winner)*BeW +: BeW];
  assign mgr_wdata_o = sbr_wdata_i[int'(winner)*DataWidth +: DataWidth];

  // Responses return in issue order, so the FIFO head names the destination port.
  assign head_id = id_mem[rd_ptr_q];
  assign pop     = rst_ni & mgr_rvalid_i & !fifo_empty;

  always_comb begin
    sbr_rvalid_o = '0;
    if (pop) sbr_rvalid_o[head_id] = 1'b1;
  end

  assign sbr_rdata_o = mgr_rdata_i;
  assign sbr_err_o   = mgr_err_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:     if (mgr_req_o && !mgr_gnt_i) state_d = HOLD;
      HOLD:    if (handshake)               state_d = ARB;
      default:                              state_d = ARB;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB && state_d == HOLD) lock_idx_q <= winner;
      if (handshake) begin
        rr_ptr_q <= (winner == idx_t'(NumSbrPorts - 1)) ? '0 : winner + idx_t'(1);
        wr_ptr_q <= (wr_ptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      unique case ({handshake, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: ID storage is not reset; cnt_q and the pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (handshake) id_mem[wr_ptr_q] <= winner;
  end

  spurious_rsp_a: assert property (@(posedge clk_i) disable iff (!rst_ni || !FlagSpuriousRsp)
    !(mgr_rvalid_i && fifo_empty));

  gnt_onehot_a: assert property (@(posedge clk_i) $onehot0(sbr_gnt_o));

endmodule
